bg_rle_fetch: RTL and testbench



---
 rtl/bg_rle_fetch_if.sv | 34 +++
 rtl/bg_rle_fetch.sv | 189 ++++++++++++++++++
 tb/tb_bg_rle_fetch.sv | 363 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bg_rle_fetch_if.sv
// bg_rle_fetch_if: bundles the VGA-timing, ROM and decoder-facing signals of bg_rle_fetch.
//   frame_start  start-of-frame pulse              (to fetcher)
//   pix_en       one pulse per consumed pixel      (to fetcher)
//   rom_addr     registered ROM read address       (from fetcher)
//   rom_data     ROM word {run, idx}, 1-clk latency (to fetcher)
//   pre_bg_pixel palette index to the decoder      (from fetcher)
//   pix_valid    pre_bg_pixel holds a run pixel    (from fetcher)
//   underrun     sticky pixel-starvation flag      (from fetcher)
//   fmt_err      sticky run-crossed-line flag      (from fetcher)
// master: the fetcher; slave: its environment (timing block, ROM, decoder).
interface bg_rle_fetch_if #(
  parameter int unsigned IDX_W  = 5,
  parameter int unsigned RUN_W  = 7,
  parameter int unsigned ADDR_W = 15
);
  logic                   frame_start;
  logic                   pix_en;
  logic [ADDR_W-1:0]      rom_addr;
  logic [RUN_W+IDX_W-1:0] rom_data;
  logic [IDX_W-1:0]       pre_bg_pixel;
  logic                   pix_valid;
  logic                   underrun;
  logic                   fmt_err;

  modport master (
    input  frame_start, pix_en, rom_data,
    output rom_addr, pre_bg_pixel, pix_valid, underrun, fmt_err
  );

  modport slave (
    output frame_start, pix_en, rom_data,
    input  rom_addr, pre_bg_pixel, pix_valid, underrun, fmt_err
  );
endinterface

// File: rtl/bg_rle_fetch.sv
// bg_rle_fetch: reads a run-length-encoded background from a synchronous ROM in raster order,
// replicates every pixel SCALE times horizontally and every source line SCALE times
// vertically, and presents one palette index per pix_en to the background decoder.
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  bg_rle_fetch_if.master: frame_start/pix_en in, rom_addr out, rom_data in,
//        pre_bg_pixel/pix_valid/underrun/fmt_err out
// Optional build macro BG_RLE_LINE_CHECK_EN: when defined, fmt_err flags a run whose length
// overruns its source line; otherwise fmt_err is tied low. Pixel output is identical either way.
module bg_rle_fetch #(
  parameter int unsigned IDX_W  = 5,
  parameter int unsigned RUN_W  = 7,
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned IMG_W  = 320,
  parameter int unsigned IMG_H  = 240,
  parameter int unsigned SCALE  = 2
) (
  input logic            clk,
  input logic            rst,
  bg_rle_fetch_if.master bus
);

  localparam int unsigned XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int unsigned SW = (SCALE > 1) ? $clog2(SCALE) : 1;

  localparam logic [XW-1:0] XLast = XW'(IMG_W - 1);
  localparam logic [YW-1:0] YLast = YW'(IMG_H - 1);
  localparam logic [SW-1:0] SLast = SW'(SCALE - 1);

  typedef enum logic [2:0] {StIdle, StFetch, StLoad, StRun, StDone} state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
  logic [ADDR_W-1:0]  line_base_q, line_base_d;
  logic [RUN_W-1:0]   run_cnt_q, run_cnt_d;
  logic [SW-1:0]      hsub_q, hsub_d;
  logic [XW-1:0]      src_x_q, src_x_d;
  logic [SW-1:0]      vsub_q, vsub_d;
  logic [YW-1:0]      src_y_q, src_y_d;
  logic [IDX_W-1:0]   pixel_q, pixel_d;
  logic               valid_q, valid_d;
  logic               underrun_q, underrun_d;

  logic               hsub_wrap;
  logic               line_end;

  assign hsub_wrap = (hsub_q == SLast);
  assign line_end  = (src_x_q == XLast);

  always_comb begin
    state_d     = state_q;
    rom_addr_d  = rom_addr_q;
    line_base_d = line_base_q;
    run_cnt_d   = run_cnt_q;
    hsub_d      = hsub_q;
    src_x_d     = src_x_q;
    vsub_d      = vsub_q;
    src_y_d     = src_y_q;
    pixel_d     = pixel_q;
    valid_d     = valid_q;
    underrun_d  = underrun_q;

    if (bus.frame_start) begin
      // Restart wins over everything, including a coincident pix_en.
      state_d     = StFetch;
      rom_addr_d  = '0;
      line_base_d = '0;
      run_cnt_d   = '0;
      hsub_d      = '0;
      src_x_d     = '0;
      vsub_d      = '0;
      src_y_d     = '0;
      valid_d     = 1'b0;
      underrun_d  = 1'b0;
    end else begin
      unique case (state_q)
        StFetch: begin
          state_d = StLoad;
          if (bus.pix_en) underrun_d = 1'b1;
        end
        StLoad: begin
          run_cnt_d = bus.rom_data[RUN_W+IDX_W-1 -: RUN_W];
          pixel_d   = bus.rom_data[IDX_W-1:0];
          valid_d   = 1'b1;
          state_d   = StRun;
          if (bus.pix_en) underrun_d = 1'b1;
        end
        StRun: begin
          if (bus.pix_en) begin
            if (!hsub_wrap) begin
              hsub_d = hsub_q + 1'b1;
            end else begin
              hsub_d = '0;
              if (line_end) begin
                // Line end truncates whatever is left of the current run.
                valid_d = 1'b0;
                src_x_d = '0;
                if (vsub_q != SLast) begin
                  vsub_d     = vsub_q + 1'b1;
                  rom_addr_d = line_base_q;
                  state_d    = StFetch;
                end else if (src_y_q != YLast) begin
                  vsub_d      = '0;
                  src_y_d     = src_y_q + 1'b1;
                  rom_addr_d  = rom_addr_q + 1'b1;
                  line_base_d = rom_addr_q + 1'b1;
                  state_d     = StFetch;
                end else begin
                  state_d = StDone;
                end
              end else if (run_cnt_q == '0) begin
                valid_d    = 1'b0;
                src_x_d    = src_x_q + 1'b1;
                rom_addr_d = rom_addr_q + 1'b1;
                state_d    = StFetch;
              end else begin
                src_x_d   = src_x_q + 1'b1;
                run_cnt_d = run_cnt_q - 1'b1;
              end
            end
          end
        end
        StIdle, StDone: begin
          valid_d = 1'b0;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      rom_addr_q  <= '0;
      line_base_q <= '0;
      run_cnt_q   <= '0;
      hsub_q      <= '0;
      src_x_q     <= '0;
      vsub_q      <= '0;
      src_y_q     <= '0;
      pixel_q     <= '0;
      valid_q     <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rom_addr_q  <= rom_addr_d;
      line_base_q <= line_base_d;
      run_cnt_q   <= run_cnt_d;
      hsub_q      <= hsub_d;
      src_x_q     <= src_x_d;
      vsub_q      <= vsub_d;
      src_y_q     <= src_y_d;
      pixel_q     <= pixel_d;
      valid_q     <= valid_d;
      underrun_q  <= underrun_d;
    end
  end

  assign bus.rom_addr     = rom_addr_q;
  assign bus.pre_bg_pixel = pixel_q;
  assign bus.pix_valid    = valid_q;
  assign bus.underrun     = underrun_q;

`ifdef BG_RLE_LINE_CHECK_EN
  logic fmt_err_q;
  logic fmt_set;

  // A non-zero residual run count at a line end means the run overran the line.
  assign fmt_set = !bus.frame_start && (state_q == StRun) && bus.pix_en && hsub_wrap &&
                   line_end && (run_cnt_q != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fmt_err_q <= 1'b0;
    end else if (bus.frame_start) begin
      fmt_err_q <= 1'b0;
    end else if (fmt_set) begin
      fmt_err_q <= 1'b1;
    end
  end

  assign bus.fmt_err = fmt_err_q;
`else
  assign bus.fmt_err = 1'b0;
`endif

endmodule

// File: tb/tb_bg_rle_fetch.sv
// tb_bg_rle_fetch: self-checking bench for bg_rle_fetch with a 4x2 image scaled by 2.
// A synchronous ROM model feeds the DUT; expected pixels and fetch addresses come from a
// line-by-line decode of the ROM contents.
module tb_bg_rle_fetch;

  localparam int W = 4;
  localparam int H = 2;
  localparam int S = 2;

  logic clk;
  logic rst;
  logic clk_run;

  int n_checks;
  int n_fail;

  logic [11:0] rom_mem [0:63];
  logic [4:0]  exp_pix[$];
  logic [14:0] exp_fetch[$];
  logic [14:0] fetch_q[$];
  logic        exp_fmt;
  logic        fmt_exp;
  logic        prev_valid;

  bg_rle_fetch_if #(.IDX_W(5), .RUN_W(7), .ADDR_W(15)) bus ();

  bg_rle_fetch #(
    .IDX_W (5),
    .RUN_W (7),
    .ADDR_W(15),
    .IMG_W (W),
    .IMG_H (H),
    .SCALE (S)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  always @(posedge clk) bus.rom_data <= rom_mem[bus.rom_addr[5:0]];

  // Each rising pix_valid marks a completed fetch; record the address it came from.
  always @(negedge clk) begin
    if (bus.pix_valid === 1'b1 && prev_valid !== 1'b1) fetch_q.push_back(bus.rom_addr);
    prev_valid <= bus.pix_valid;
  end

  task automatic clear_rom();
    for (int i = 0; i < 64; i++) rom_mem[i] = '0;
  endtask

  // Decode the ROM the way the image format defines it: each source line starts on a new
  // word, runs are clipped at the line end, and the line is replayed S times.
  task automatic build_expect();
    int base, a, x, run, n;
    logic [11:0] word;
    exp_pix.delete();
    exp_fetch.delete();
    exp_fmt = 1'b0;
    base = 0;
    a = 0;
    for (int y = 0; y < H; y++) begin
      for (int v = 0; v < S; v++) begin
        a = base;
        x = 0;
        while (x < W) begin
          word = rom_mem[a];
          run = int'(word[11:5]) + 1;
          exp_fetch.push_back(15'(a));
          n = (run > W - x) ? (W - x) : run;
          if (run > W - x) exp_fmt = 1'b1;
          for (int k = 0; k < n * S; k++) exp_pix.push_back(word[4:0]);
          x += n;
          a++;
        end
      end
      base = a;
    end
`ifdef BG_RLE_LINE_CHECK_EN
    fmt_exp = exp_fmt;
`else
    fmt_exp = 1'b0;
`endif
  endtask

  task automatic load_spec_rom();
    clear_rom();
    rom_mem[0] = {7'd3, 5'd5};
    rom_mem[1] = {7'd1, 5'd7};
    rom_mem[2] = {7'd1, 5'd2};
  endtask

  task automatic start_frame();
    @(negedge clk);
    fetch_q.delete();
    bus.frame_start = 1'b1;
    @(negedge clk);
    bus.frame_start = 1'b0;
  endtask

  task automatic run_pixels(input int first, input int count);
    int gap;
    for (int i = first; i < first + count; i++) begin
      gap = $urandom_range(4, 7);
      repeat (gap - 1) @(negedge clk);
      n_checks++;
      if (bus.pix_valid !== 1'b1 || bus.pre_bg_pixel !== exp_pix[i]) begin
        n_fail++;
        $display("FAIL pixel[%0d]: valid=%b idx=%0d, required valid=1 idx=%0d",
                 i, bus.pix_valid, bus.pre_bg_pixel, exp_pix[i]);
      end
      bus.pix_en = 1'b1;
      @(negedge clk);
      bus.pix_en = 1'b0;
    end
  endtask

  task automatic check_fetch(input string name);
    n_checks++;
    if (fetch_q.size() != exp_fetch.size()) begin
      n_fail++;
      $display("FAIL %s fetch count: %0d, required %0d", name, fetch_q.size(), exp_fetch.size());
    end else begin
      for (int i = 0; i < exp_fetch.size(); i++) begin
        n_checks++;
        if (fetch_q[i] !== exp_fetch[i]) begin
          n_fail++;
          $display("FAIL %s fetch[%0d]: addr=%0d, required %0d", name, i, fetch_q[i],
                   exp_fetch[i]);
        end
      end
    end
  endtask

  task automatic check_done(input string name, input logic exp_under);
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.pix_valid !== 1'b0 || bus.underrun !== exp_under || bus.fmt_err !== fmt_exp) begin
      n_fail++;
      $display("FAIL %s done flags: valid=%b underrun=%b fmt_err=%b, required 0 %b %b",
               name, bus.pix_valid, bus.underrun, bus.fmt_err, exp_under, fmt_exp);
    end
    n_checks++;
    if (bus.rom_addr !== exp_fetch[exp_fetch.size() - 1]) begin
      n_fail++;
      $display("FAIL %s done addr: %0d, required %0d", name, bus.rom_addr,
               exp_fetch[exp_fetch.size() - 1]);
    end
  endtask

  task automatic check_zero(input string name);
    n_checks++;
    if (bus.rom_addr !== 15'd0 || bus.pre_bg_pixel !== 5'd0 || bus.pix_valid !== 1'b0 ||
        bus.underrun !== 1'b0 || bus.fmt_err !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: addr=%0d idx=%0d valid=%b underrun=%b fmt_err=%b, required all 0",
               name, bus.rom_addr, bus.pre_bg_pixel, bus.pix_valid, bus.underrun, bus.fmt_err);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    check_zero("reset without clock");
    #2;
    rst = 1'b0;
    clk_run = 1'b1;
    repeat (4) @(negedge clk);
    check_zero("after reset release");
    // pix_en while idle is ignored and raises no flag
    bus.pix_en = 1'b1;
    @(negedge clk);
    bus.pix_en = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("pix_en while idle");
  endtask

  task automatic test_full_frame();
    load_spec_rom();
    build_expect();
    start_frame();
    run_pixels(0, 32);
    check_fetch("full_frame");
    check_done("full_frame", 1'b0);
  endtask

  task automatic test_random_frames();
    int a, x, len;
    logic [6:0] r;
    logic [4:0] ix;
    for (int t = 0; t < 6; t++) begin
      clear_rom();
      a = 0;
      for (int y = 0; y < H; y++) begin
        x = 0;
        while (x < W) begin
          len = $urandom_range(1, W - x + 2);
          r = 7'(len - 1);
          ix = 5'($urandom_range(0, 31));
          rom_mem[a] = {r, ix};
          x += (len > W - x) ? (W - x) : len;
          a++;
        end
      end
      build_expect();
      start_frame();
      run_pixels(0, exp_pix.size());
      check_fetch("random_frame");
      check_done("random_frame", 1'b0);
    end
  endtask

  task automatic test_restart();
    load_spec_rom();
    build_expect();
    start_frame();
    run_pixels(0, 10);
    @(negedge clk);
    fetch_q.delete();
    bus.frame_start = 1'b1;
    @(negedge clk);
    bus.frame_start = 1'b0;
    n_checks++;
    if (bus.rom_addr !== 15'd0 || bus.pix_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL restart clear: addr=%0d valid=%b, required 0 0", bus.rom_addr,
               bus.pix_valid);
    end
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.pix_valid !== 1'b1 || bus.pre_bg_pixel !== 5'd5) begin
      n_fail++;
      $display("FAIL restart reload: valid=%b idx=%0d, required 1 5", bus.pix_valid,
               bus.pre_bg_pixel);
    end
    run_pixels(0, 32);
    check_fetch("restart");
    check_done("restart", 1'b0);
  endtask

  task automatic test_underrun();
    load_spec_rom();
    build_expect();
    start_frame();
    run_pixels(0, 7);
    // Pixel 7 exhausts the first run; hold pix_en one extra clock so it lands in FETCH.
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.pix_valid !== 1'b1 || bus.pre_bg_pixel !== exp_pix[7]) begin
      n_fail++;
      $display("FAIL underrun pixel7: valid=%b idx=%0d, required 1 %0d", bus.pix_valid,
               bus.pre_bg_pixel, exp_pix[7]);
    end
    bus.pix_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.pix_en = 1'b0;
    n_checks++;
    if (bus.underrun !== 1'b1) begin
      n_fail++;
      $display("FAIL underrun set: underrun=%b, required 1", bus.underrun);
    end
    run_pixels(8, 24);
    check_fetch("underrun");
    check_done("underrun", 1'b1);
    start_frame();
    n_checks++;
    if (bus.underrun !== 1'b0) begin
      n_fail++;
      $display("FAIL underrun clear: underrun=%b, required 0", bus.underrun);
    end
  endtask

  task automatic test_line_check();
    clear_rom();
    rom_mem[0] = {7'd5, 5'd3};
    rom_mem[1] = {7'd3, 5'd4};
    build_expect();
    start_frame();
    run_pixels(0, 8);
    n_checks++;
    if (bus.fmt_err !== fmt_exp) begin
      n_fail++;
      $display("FAIL line_check fmt_err: %b, required %b", bus.fmt_err, fmt_exp);
    end
    run_pixels(8, 24);
    check_fetch("line_check");
    check_done("line_check", 1'b0);
  endtask

  task automatic test_simultaneous();
    load_spec_rom();
    build_expect();
    start_frame();
    run_pixels(0, 3);
    repeat (2) @(negedge clk);
    fetch_q.delete();
    bus.frame_start = 1'b1;
    bus.pix_en = 1'b1;
    @(negedge clk);
    bus.frame_start = 1'b0;
    bus.pix_en = 1'b0;
    n_checks++;
    if (bus.rom_addr !== 15'd0 || bus.pix_valid !== 1'b0 || bus.underrun !== 1'b0) begin
      n_fail++;
      $display("FAIL simultaneous: addr=%0d valid=%b underrun=%b, required 0 0 0",
               bus.rom_addr, bus.pix_valid, bus.underrun);
    end
    run_pixels(0, 32);
    check_fetch("simultaneous");
    check_done("simultaneous", 1'b0);
  endtask

  task automatic test_async_reset();
    load_spec_rom();
    build_expect();
    start_frame();
    run_pixels(0, 20);
    @(negedge clk);
    clk_run = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_zero("async reset mid-frame");
    #2;
    rst = 1'b0;
    clk_run = 1'b1;
    repeat (4) @(negedge clk);
    check_zero("after mid-frame reset");
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    clk_run = 1'b0;
    rst = 1'b1;
    prev_valid = 1'b0;
    bus.frame_start = 1'b0;
    bus.pix_en = 1'b0;
    clear_rom();
    fmt_exp = 1'b0;

    test_reset();
    test_full_frame();
    test_random_frames();
    test_restart();
    test_underrun();
    test_line_check();
    test_simultaneous();
    test_async_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
